reg_writeback_ctrl: RTL and testbench



---
 rtl/reg_wb_pkg.sv | 23 ++
 rtl/wb_fifo.sv | 87 ++++++++
 rtl/reg_writeback_ctrl.sv | 130 +++++++++++++
 tb/tb_reg_writeback_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared constants and the FIFO entry type for the writeback
// controller of the 64-bit core.
//   XLEN, REG_ADDR_W : data and register-address widths
//   NUM_REGS_DEF     : default number of architectural registers
//   ZERO_REG, CONST_REG : registers that are never written
//   DROP_W           : width of the saturating drop counter
//   wb_entry_t       : one pending register write {dest, data}
package reg_wb_pkg;

  localparam int XLEN         = 64;
  localparam int REG_ADDR_W   = 8;
  localparam int NUM_REGS_DEF = 100;
  localparam int DROP_W       = 16;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG  = 8'd0;
  localparam logic [REG_ADDR_W-1:0] CONST_REG = 8'd1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small ordered FIFO of pending register writes.
// Optional feature macro: WB_FWD_EN (adds the age-ordered entry export).
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   push, push_entry enqueue one entry (ignored when full)
//   pop             dequeue the head (ignored when empty)
//   head            current head entry (raw storage, caller gates it)
//   empty, full     occupancy flags
//   age_entry/age_valid (WB_FWD_EN) entries ordered oldest (0) to youngest
import reg_wb_pkg::*;

module wb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      empty,
  output logic      full
`ifdef WB_FWD_EN
  ,
  output wb_entry_t        age_entry [DEPTH],
  output logic [DEPTH-1:0] age_valid
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leaves the count unchanged.
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; consumers gate it with the count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

`ifdef WB_FWD_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_entry[i] = mem_q[rd_ptr_q + PTR_W'(i)];
      age_valid[i] = (CNT_W'(i) < count_q);
    end
  end
`endif

endmodule

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: arbitrates ALU and load results into an ordered FIFO
// and retires one register-file write per cycle. Writes to r0, r1 or
// addresses >= NUM_REGS are accepted but discarded and counted.
// Optional feature macro: WB_FWD_EN (forwarding lookup ports).
// Ports:
//   clock, reset                    clock, asynchronous active-high reset
//   alu_valid/ready/dest/data       ALU result stream (lower priority)
//   mem_valid/ready/dest/data       load result stream (higher priority)
//   reg_write, reg_write_data       register file write address / data
//   reg_write_cmd                   register file write strobe
//   drop_count                      saturating count of discarded writes
//   fifo_empty                      no pending writes
//   fwd_addr_n, fwd_hit_n, fwd_data_n (WB_FWD_EN) forwarding lookups
import reg_wb_pkg::*;

module reg_writeback_ctrl #(
  parameter int DEPTH    = 4,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_dest,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic [XLEN-1:0]       mem_data,
  output logic [REG_ADDR_W-1:0] reg_write,
  output logic [XLEN-1:0]       reg_write_data,
  output logic                  reg_write_cmd,
  output logic [DROP_W-1:0]     drop_count,
  output logic                  fifo_empty
`ifdef WB_FWD_EN
  ,
  input  logic [REG_ADDR_W-1:0] fwd_addr_1,
  input  logic [REG_ADDR_W-1:0] fwd_addr_2,
  output logic                  fwd_hit_1,
  output logic                  fwd_hit_2,
  output logic [XLEN-1:0]       fwd_data_1,
  output logic [XLEN-1:0]       fwd_data_2
`endif
);

  function automatic logic dest_ok(input logic [REG_ADDR_W-1:0] d);
    return (d != ZERO_REG) && (d != CONST_REG) && (int'(d) < NUM_REGS);
  endfunction

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic             space, empty, full;
  logic             mem_fire, alu_fire, any_fire, push, drop;
  wb_entry_t        push_entry, head;
  logic [DROP_W-1:0] drop_count_q, drop_count_d;

  always_comb begin
    // No credit for a same-cycle pop: space depends on the count only.
    space     = ~full;
    mem_ready = space & ~reset;
    alu_ready = space & ~mem_valid & ~reset;
    mem_fire  = mem_valid & mem_ready;
    alu_fire  = alu_valid & alu_ready;
    any_fire  = mem_fire | alu_fire;
    push_entry.dest = mem_fire ? mem_dest : alu_dest;
    push_entry.data = mem_fire ? mem_data : alu_data;
    push      = any_fire & dest_ok(push_entry.dest);
    drop      = any_fire & ~dest_ok(push_entry.dest);
    drop_count_d = drop ? sat_inc(drop_count_q) : drop_count_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

`ifdef WB_FWD_EN
  wb_entry_t        age_entry [DEPTH];
  logic [DEPTH-1:0] age_valid;
`endif

  // The register file never stalls, so the head is popped whenever present.
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clock),
    .rst        (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (~empty),
    .head       (head),
    .empty      (empty),
    .full       (full)
`ifdef WB_FWD_EN
    ,
    .age_entry  (age_entry),
    .age_valid  (age_valid)
`endif
  );

  assign reg_write_cmd  = ~empty;
  assign reg_write      = empty ? '0 : head.dest;
  assign reg_write_data = empty ? '0 : head.data;
  assign fifo_empty     = empty;
  assign drop_count     = drop_count_q;

`ifdef WB_FWD_EN
  // Scanning oldest to youngest lets the youngest match overwrite older ones.
  always_comb begin
    fwd_hit_1  = 1'b0;
    fwd_hit_2  = 1'b0;
    fwd_data_1 = '0;
    fwd_data_2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_valid[i] && (age_entry[i].dest == fwd_addr_1)) begin
        fwd_hit_1  = 1'b1;
        fwd_data_1 = age_entry[i].data;
      end
      if (age_valid[i] && (age_entry[i].dest == fwd_addr_2)) begin
        fwd_hit_2  = 1'b1;
        fwd_data_2 = age_entry[i].data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb_reg_writeback_ctrl: directed and randomized checks of reg_writeback_ctrl
// against a queue-based reference model of pending writes.
module tb_reg_writeback_ctrl;

  localparam int DEPTH    = 4;
  localparam int NUM_REGS = 100;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [7:0]  alu_dest, mem_dest;
  logic [63:0] alu_data, mem_data;
  logic [7:0]  reg_write;
  logic [63:0] reg_write_data;
  logic        reg_write_cmd;
  logic [15:0] drop_count;
  logic        fifo_empty;
  logic [7:0]  fwd_addr_1, fwd_addr_2;
`ifdef WB_FWD_EN
  logic        fwd_hit_1, fwd_hit_2;
  logic [63:0] fwd_data_1, fwd_data_2;
`endif

  always #5 clock = ~clock;

  reg_writeback_ctrl #(.DEPTH(DEPTH), .NUM_REGS(NUM_REGS)) dut (
    .clock          (clock),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_dest       (alu_dest),
    .alu_data       (alu_data),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_dest       (mem_dest),
    .mem_data       (mem_data),
    .reg_write      (reg_write),
    .reg_write_data (reg_write_data),
    .reg_write_cmd  (reg_write_cmd),
    .drop_count     (drop_count),
    .fifo_empty     (fifo_empty)
`ifdef WB_FWD_EN
    ,
    .fwd_addr_1     (fwd_addr_1),
    .fwd_addr_2     (fwd_addr_2),
    .fwd_hit_1      (fwd_hit_1),
    .fwd_hit_2      (fwd_hit_2),
    .fwd_data_1     (fwd_data_1),
    .fwd_data_2     (fwd_data_2)
`endif
  );

  typedef struct {
    logic [7:0]  d;
    logic [63:0] v;
  } ent_t;

  ent_t q[$];
  int   exp_drop = 0;
  int   n_cmp    = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit nonempty = (q.size() > 0);
    chk("reg_write_cmd", reg_write_cmd, nonempty);
    chk("fifo_empty", fifo_empty, !nonempty);
    chk("reg_write", reg_write, nonempty ? q[0].d : 8'd0);
    chk("reg_write_data", reg_write_data, nonempty ? q[0].v : 64'd0);
    chk("drop_count", drop_count, exp_drop);
  endtask

`ifdef WB_FWD_EN
  task automatic check_fwd(input string tag, input logic [7:0] a,
                           input logic hit, input logic [63:0] data);
    bit          eh = 0;
    logic [63:0] ed = '0;
    foreach (q[i]) if (q[i].d == a) begin eh = 1; ed = q[i].v; end
    chk({tag, "_hit"}, hit, eh);
    chk({tag, "_data"}, data, ed);
  endtask
`endif

  // One cycle: drive at the falling edge, check before the rising edge,
  // then advance the model by what the rising edge should do.
  task automatic step(input logic mv, input logic [7:0] md, input logic [63:0] mdat,
                      input logic av, input logic [7:0] ad, input logic [63:0] adat,
                      input logic [7:0] fa1, input logic [7:0] fa2);
    bit          sp, mf, af;
    logic [7:0]  d;
    logic [63:0] v;
    mem_valid = mv; mem_dest = md; mem_data = mdat;
    alu_valid = av; alu_dest = ad; alu_data = adat;
    fwd_addr_1 = fa1; fwd_addr_2 = fa2;
    #1;
    sp = (q.size() < DEPTH);
    chk("mem_ready", mem_ready, sp);
    chk("alu_ready", alu_ready, sp && !mv);
    check_outputs();
`ifdef WB_FWD_EN
    check_fwd("fwd1", fa1, fwd_hit_1, fwd_data_1);
    check_fwd("fwd2", fa2, fwd_hit_2, fwd_data_2);
`endif
    @(posedge clock);
    mf = mv && sp;
    af = av && sp && !mv;
    if (q.size() > 0) void'(q.pop_front());
    if (mf || af) begin
      d = mf ? md : ad;
      v = mf ? mdat : adat;
      if (d >= 2 && int'(d) < NUM_REGS) q.push_back('{d, v});
      else if (exp_drop < 65535) exp_drop++;
    end
    @(negedge clock);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    mem_valid = 0; mem_dest = 0; mem_data = 0;
    alu_valid = 0; alu_dest = 0; alu_data = 0;
    fwd_addr_1 = 0; fwd_addr_2 = 0;
    #2;
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_cmd", reg_write_cmd, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_drop", drop_count, 0);
    chk("rst_reg_write", reg_write, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post_rst_alu_ready", alu_ready, 1);
    chk("post_rst_mem_ready", mem_ready, 1);

    // Single ALU write, one-cycle latency, then idle.
    step(0, 0, 0, 1, 8'd5, 64'hDEAD, 0, 0);
    chk("t1_cmd", reg_write_cmd, 1);
    chk("t1_addr", reg_write, 8'd5);
    chk("t1_data", reg_write_data, 64'hDEAD);
    idle();
    chk("t1_cmd_off", reg_write_cmd, 0);
    chk("t1_empty", fifo_empty, 1);

    // mem wins over alu; alu holds and goes next.
    step(1, 8'd3, 64'h11, 1, 8'd4, 64'h22, 0, 0);
    chk("t2_first", reg_write, 8'd3);
    step(0, 0, 0, 1, 8'd4, 64'h22, 0, 0);
    chk("t2_second", reg_write, 8'd4);
    chk("t2_second_data", reg_write_data, 64'h22);
    idle();

    // Five back-to-back ALU pushes.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 8'(10 + i), 64'(100 + i), 0, 0);
      chk("t3_order", reg_write, 8'(10 + i));
    end
    idle();

    // Filtered destinations.
    step(0, 0, 0, 1, 8'd0, 64'h1, 0, 0);
    chk("t4_cmd0", reg_write_cmd, 0);
    step(0, 0, 0, 1, 8'd1, 64'h2, 0, 0);
    chk("t4_cmd1", reg_write_cmd, 0);
    step(0, 0, 0, 1, 8'd120, 64'h3, 0, 0);
    chk("t4_cmd120", reg_write_cmd, 0);
    chk("t4_drop", drop_count, 16'd3);
    idle();

    // Youngest write to r7 is forwarded.
    step(0, 0, 0, 1, 8'd7, 64'd1, 8'd7, 8'd9);
    step(0, 0, 0, 1, 8'd7, 64'd2, 8'd7, 8'd9);
`ifdef WB_FWD_EN
    chk("t5_hit1", fwd_hit_1, 1);
    chk("t5_data1", fwd_data_1, 64'd2);
    chk("t5_hit2", fwd_hit_2, 0);
`endif
    idle();

    // Asynchronous reset with a write pending.
    step(0, 0, 0, 1, 8'd10, 64'hABC, 0, 0);
    alu_valid = 0;
    #2 reset = 1'b1;
    #1;
    chk("t6_cmd", reg_write_cmd, 0);
    chk("t6_empty", fifo_empty, 1);
    chk("t6_drop", drop_count, 0);
    chk("t6_ready", alu_ready, 0);
    q.delete();
    exp_drop = 0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("t6_ready_after", alu_ready, 1);
    idle();
    chk("t6_no_stale", reg_write_cmd, 0);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic       mv, av;
      logic [7:0] md, ad;
      int         r;
      mv = ($urandom % 3) == 0;
      av = ($urandom % 2) == 0;
      r = $urandom % 8;
      md = (r == 0) ? 8'd0 : (r == 1) ? 8'd1 : (r == 2) ? 8'($urandom_range(100, 255))
                                                       : 8'($urandom_range(2, 12));
      r = $urandom % 8;
      ad = (r == 0) ? 8'd0 : (r == 1) ? 8'd1 : (r == 2) ? 8'($urandom_range(100, 255))
                                                       : 8'($urandom_range(2, 12));
      step(mv, md, {$urandom, $urandom}, av, ad, {$urandom, $urandom},
           8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
